// File: rtl/rf_sb_if.sv
`default_nettype none
// ============================================================================
//  Module   : rf_sb_if
//  Purpose  : Write, read and issue/scoreboard signal bundle for rf_sb.
//  Revision : 1.0  initial release
// ============================================================================
interface rf_sb_if #(
    parameter int DW  = 8,
    parameter int RFW = 2,
    parameter int NRD = 2
);
    logic                 wr0_en;
    logic [RFW-1:0]       wr0_addr;
    logic [DW-1:0]        wr0_data;
    logic                 wr1_en;
    logic [RFW-1:0]       wr1_addr;
    logic [DW-1:0]        wr1_data;
    logic [NRD*RFW-1:0]   rd_addr;
    logic [NRD*DW-1:0]    rd_data;
    logic [NRD-1:0]       rd_busy;
    logic                 iss_en;
    logic [RFW-1:0]       iss_addr;
    logic                 iss_ok;
    logic [(2**RFW)-1:0]  busy_vec;
    logic                 err;

    modport master (
        output wr0_en, wr0_addr, wr0_data,
        output wr1_en, wr1_addr, wr1_data,
        output rd_addr, iss_en, iss_addr,
        input  rd_data, rd_busy, iss_ok, busy_vec, err
    );

    modport slave (
        input  wr0_en, wr0_addr, wr0_data,
        input  wr1_en, wr1_addr, wr1_data,
        input  rd_addr, iss_en, iss_addr,
        output rd_data, rd_busy, iss_ok, busy_vec, err
    );
endinterface
`default_nettype wire

// File: rtl/rf_sb.sv
`default_nettype none
// ============================================================================
//  Module   : rf_sb
//  Purpose  : Two-write, NRD-read register file with bypass and busy scoreboard.
//  Revision : 1.0  initial release
// ============================================================================
module rf_sb #(
    parameter int DW  = 8,
    parameter int RFW = 2,
    parameter int NRD = 2
) (
    input  wire logic  clk,
    input  wire logic  rst,
    rf_sb_if.slave     bus
);
    localparam int NREG = 2**RFW;

    logic [NREG-1:0][DW-1:0] regs;
    logic [NREG-1:0]         busy;
    logic [NREG-1:0]         busy_nxt;
    logic [NREG-1:0]         wr_hit;
    logic [NREG-1:0]         eff_busy;
    logic                    iss_ok;
    logic                    iss_accept;
    logic                    err;
    logic [NRD*DW-1:0]       rd_data;
    logic [NRD-1:0]          rd_busy;
    logic [RFW-1:0]          rd_sel;

    // Storage: register 0 stays at its reset value of zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int r = 0; r < NREG; r++) begin
                regs[r] <= (r == 0) ? '0 : '1;
            end
        end else begin
            if (bus.wr0_en && (bus.wr0_addr != '0)) begin
                regs[bus.wr0_addr] <= bus.wr0_data;
            end
            // Later assignment gives port 1 priority on a collision.
            if (bus.wr1_en && (bus.wr1_addr != '0)) begin
                regs[bus.wr1_addr] <= bus.wr1_data;
            end
        end
    end

    always_comb begin
        wr_hit = '0;
        for (int r = 0; r < NREG; r++) begin
            wr_hit[r] = (bus.wr0_en && (bus.wr0_addr == RFW'(r))) ||
                        (bus.wr1_en && (bus.wr1_addr == RFW'(r)));
        end
    end

    // A write in flight retires its producer in the same cycle.
    assign eff_busy   = busy & ~wr_hit;
    assign iss_ok     = ~eff_busy[bus.iss_addr];
    assign iss_accept = bus.iss_en && iss_ok && (bus.iss_addr != '0);

    always_comb begin
        busy_nxt = busy & ~wr_hit;
        if (iss_accept) begin
            busy_nxt[bus.iss_addr] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
            err  <= 1'b0;
        end else begin
            busy <= busy_nxt;
            if (bus.iss_en && !iss_ok) begin
                err <= 1'b1;
            end
        end
    end

    // Read ports: wr1 bypass, then wr0 bypass, then array; bypass off during reset.
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_sel  = '0;
        for (int k = 0; k < NRD; k++) begin
            rd_sel = bus.rd_addr[k*RFW +: RFW];
            if (rd_sel == '0) begin
                rd_data[k*DW +: DW] = '0;
            end else if (!rst && bus.wr1_en && (bus.wr1_addr == rd_sel)) begin
                rd_data[k*DW +: DW] = bus.wr1_data;
            end else if (!rst && bus.wr0_en && (bus.wr0_addr == rd_sel)) begin
                rd_data[k*DW +: DW] = bus.wr0_data;
            end else begin
                rd_data[k*DW +: DW] = regs[rd_sel];
            end
            rd_busy[k] = eff_busy[rd_sel];
        end
    end

    assign bus.rd_data  = rd_data;
    assign bus.rd_busy  = rd_busy;
    assign bus.iss_ok   = iss_ok;
    assign bus.busy_vec = busy;
    assign bus.err      = err;

endmodule
`default_nettype wire

// File: tb/tb_rf_sb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_rf_sb
//  Purpose  : Directed self-checking bench for rf_sb (DW=8, RFW=2, NRD=2).
//  Revision : 1.0  initial release
// ============================================================================
module tb_rf_sb;
    logic clk;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    rf_sb_if #(.DW(8), .RFW(2), .NRD(2)) bus ();

    rf_sb #(.DW(8), .RFW(2), .NRD(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr0_en = 1'b0; bus.wr0_addr = '0; bus.wr0_data = '0;
        bus.wr1_en = 1'b0; bus.wr1_addr = '0; bus.wr1_data = '0;
        bus.iss_en = 1'b0; bus.iss_addr = '0;
    endtask

    task automatic test_reset();
        bus.rd_addr = {2'd1, 2'd0};
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.rd_data !== 16'hFF00) begin errors++; $display("FAIL reset_rd_data: got %h expected %h", bus.rd_data, 16'hFF00); end
        checks++; if (bus.busy_vec !== 4'b0000) begin errors++; $display("FAIL reset_busy_vec: got %b expected %b", bus.busy_vec, 4'b0000); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b expected %b", bus.err, 1'b0); end
        checks++; if (bus.iss_ok !== 1'b1) begin errors++; $display("FAIL reset_iss_ok: got %b expected %b", bus.iss_ok, 1'b1); end
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL reset_rd_busy: got %b expected %b", bus.rd_busy, 2'b00); end
        #1 rst = 1'b0;
        step();
    endtask

    task automatic test_collision();
        bus.wr0_en = 1'b1; bus.wr0_addr = 2'd2; bus.wr0_data = 8'h11;
        bus.wr1_en = 1'b1; bus.wr1_addr = 2'd2; bus.wr1_data = 8'h22;
        bus.rd_addr = {2'd2, 2'd2};
        #1;
        checks++; if (bus.rd_data !== 16'h2222) begin errors++; $display("FAIL collision_bypass: got %h expected %h", bus.rd_data, 16'h2222); end
        step();
        idle();
        #1;
        checks++; if (bus.rd_data[7:0] !== 8'h22) begin errors++; $display("FAIL collision_stored: got %h expected %h", bus.rd_data[7:0], 8'h22); end
    endtask

    task automatic test_reg0();
        bus.wr0_en = 1'b1; bus.wr0_addr = 2'd0; bus.wr0_data = 8'h55;
        bus.rd_addr = {2'd2, 2'd0};
        #1;
        checks++; if (bus.rd_data[7:0] !== 8'h00) begin errors++; $display("FAIL reg0_bypass: got %h expected %h", bus.rd_data[7:0], 8'h00); end
        step();
        idle();
        #1;
        checks++; if (bus.rd_data[7:0] !== 8'h00) begin errors++; $display("FAIL reg0_stored: got %h expected %h", bus.rd_data[7:0], 8'h00); end
        bus.iss_en = 1'b1; bus.iss_addr = 2'd0;
        #1;
        checks++; if (bus.iss_ok !== 1'b1) begin errors++; $display("FAIL reg0_iss_ok: got %b expected %b", bus.iss_ok, 1'b1); end
        step();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 4'b0000) begin errors++; $display("FAIL reg0_busy_vec: got %b expected %b", bus.busy_vec, 4'b0000); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL reg0_err: got %b expected %b", bus.err, 1'b0); end
    endtask

    task automatic test_scoreboard();
        bus.rd_addr = {2'd3, 2'd2};
        bus.iss_en = 1'b1; bus.iss_addr = 2'd3;
        #1;
        checks++; if (bus.iss_ok !== 1'b1) begin errors++; $display("FAIL sb_first_iss_ok: got %b expected %b", bus.iss_ok, 1'b1); end
        step();
        bus.iss_en = 1'b0;
        #1;
        checks++; if (bus.busy_vec !== 4'b1000) begin errors++; $display("FAIL sb_busy_set: got %b expected %b", bus.busy_vec, 4'b1000); end
        checks++; if (bus.rd_busy !== 2'b10) begin errors++; $display("FAIL sb_rd_busy_set: got %b expected %b", bus.rd_busy, 2'b10); end
        checks++; if (bus.iss_ok !== 1'b0) begin errors++; $display("FAIL sb_iss_blocked: got %b expected %b", bus.iss_ok, 1'b0); end
        bus.iss_en = 1'b1;
        step();
        bus.iss_en = 1'b0;
        #1;
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL sb_err_set: got %b expected %b", bus.err, 1'b1); end
        checks++; if (bus.busy_vec !== 4'b1000) begin errors++; $display("FAIL sb_busy_unchanged: got %b expected %b", bus.busy_vec, 4'b1000); end
        bus.wr1_en = 1'b1; bus.wr1_addr = 2'd3; bus.wr1_data = 8'h7A;
        #1;
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL sb_rd_busy_clear: got %b expected %b", bus.rd_busy, 2'b00); end
        checks++; if (bus.iss_ok !== 1'b1) begin errors++; $display("FAIL sb_iss_ok_clear: got %b expected %b", bus.iss_ok, 1'b1); end
        checks++; if (bus.rd_data[15:8] !== 8'h7A) begin errors++; $display("FAIL sb_wr_bypass: got %h expected %h", bus.rd_data[15:8], 8'h7A); end
        step();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 4'b0000) begin errors++; $display("FAIL sb_busy_vec_clear: got %b expected %b", bus.busy_vec, 4'b0000); end
        checks++; if (bus.rd_data[15:8] !== 8'h7A) begin errors++; $display("FAIL sb_wr_stored: got %h expected %h", bus.rd_data[15:8], 8'h7A); end
    endtask

    task automatic test_clear_and_set();
        bus.rd_addr = {2'd3, 2'd1};
        bus.iss_en = 1'b1; bus.iss_addr = 2'd1;
        step();
        bus.wr0_en = 1'b1; bus.wr0_addr = 2'd1; bus.wr0_data = 8'h5C;
        #1;
        checks++; if (bus.iss_ok !== 1'b1) begin errors++; $display("FAIL cs_iss_ok: got %b expected %b", bus.iss_ok, 1'b1); end
        step();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 4'b0010) begin errors++; $display("FAIL cs_busy_vec: got %b expected %b", bus.busy_vec, 4'b0010); end
        checks++; if (bus.rd_data[7:0] !== 8'h5C) begin errors++; $display("FAIL cs_stored: got %h expected %h", bus.rd_data[7:0], 8'h5C); end
        checks++; if (bus.err !== 1'b1) begin errors++; $display("FAIL cs_err_sticky: got %b expected %b", bus.err, 1'b1); end
    endtask

    task automatic test_back_to_back();
        bus.rd_addr = {2'd2, 2'd3};
        bus.iss_en = 1'b1; bus.iss_addr = 2'd3;
        step();
        bus.iss_addr = 2'd2;
        step();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 4'b1110) begin errors++; $display("FAIL b2b_busy_vec: got %b expected %b", bus.busy_vec, 4'b1110); end
        checks++; if (bus.rd_busy !== 2'b11) begin errors++; $display("FAIL b2b_rd_busy: got %b expected %b", bus.rd_busy, 2'b11); end
        bus.wr0_en = 1'b1; bus.wr0_addr = 2'd3; bus.wr0_data = 8'hA3;
        bus.wr1_en = 1'b1; bus.wr1_addr = 2'd2; bus.wr1_data = 8'hB2;
        #1;
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL b2b_rd_busy_clear: got %b expected %b", bus.rd_busy, 2'b00); end
        checks++; if (bus.rd_data !== 16'hB2A3) begin errors++; $display("FAIL b2b_dual_bypass: got %h expected %h", bus.rd_data, 16'hB2A3); end
        step();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 4'b0010) begin errors++; $display("FAIL b2b_busy_after: got %b expected %b", bus.busy_vec, 4'b0010); end
        checks++; if (bus.rd_data !== 16'hB2A3) begin errors++; $display("FAIL b2b_stored: got %h expected %h", bus.rd_data, 16'hB2A3); end
    endtask

    task automatic test_reset_mid();
        bus.rd_addr = {2'd2, 2'd1};
        bus.wr0_en = 1'b1; bus.wr0_addr = 2'd2; bus.wr0_data = 8'h33;
        step();
        idle();
        bus.iss_en = 1'b1; bus.iss_addr = 2'd2;
        step();
        idle();
        #1;
        checks++; if (bus.busy_vec !== 4'b0110) begin errors++; $display("FAIL rm_busy_before: got %b expected %b", bus.busy_vec, 4'b0110); end
        checks++; if (bus.rd_data[15:8] !== 8'h33) begin errors++; $display("FAIL rm_data_before: got %h expected %h", bus.rd_data[15:8], 8'h33); end
        bus.wr0_en = 1'b1; bus.wr0_addr = 2'd2; bus.wr0_data = 8'h99;
        #1 rst = 1'b1;
        #1;
        checks++; if (bus.busy_vec !== 4'b0000) begin errors++; $display("FAIL rm_busy_vec: got %b expected %b", bus.busy_vec, 4'b0000); end
        checks++; if (bus.err !== 1'b0) begin errors++; $display("FAIL rm_err: got %b expected %b", bus.err, 1'b0); end
        checks++; if (bus.rd_data !== 16'hFFFF) begin errors++; $display("FAIL rm_rd_data: got %h expected %h", bus.rd_data, 16'hFFFF); end
        checks++; if (bus.rd_busy !== 2'b00) begin errors++; $display("FAIL rm_rd_busy: got %b expected %b", bus.rd_busy, 2'b00); end
        step();
        #1;
        checks++; if (bus.rd_data[15:8] !== 8'hFF) begin errors++; $display("FAIL rm_held_in_reset: got %h expected %h", bus.rd_data[15:8], 8'hFF); end
        bus.wr0_data = 8'h44;
        #1 rst = 1'b0;
        step();
        idle();
        #1;
        checks++; if (bus.rd_data[15:8] !== 8'h44) begin errors++; $display("FAIL rm_first_write: got %h expected %h", bus.rd_data[15:8], 8'h44); end
        checks++; if (bus.busy_vec !== 4'b0000) begin errors++; $display("FAIL rm_busy_after: got %b expected %b", bus.busy_vec, 4'b0000); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        idle();
        bus.rd_addr = '0;
        step();
        rst = 1'b0;
        step();
        test_reset();
        test_collision();
        test_reg0();
        test_scoreboard();
        test_clear_and_set();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
`default_nettype wire
